// File: rtl/fan_pkg.sv
// Types and helpers shared by the fan PWM transmit and capture blocks.
// Both ends derive their step size from step_clks() so the step grid matches.
package fan_pkg;

  localparam int DUTY_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  function automatic int step_clks(input int clk_hz, input int pwm_hz, input int res);
    return clk_hz / (pwm_hz * res);
  endfunction

endpackage

// File: rtl/pwm_sync_edge.sv
// Two-flop synchronizer with single-cycle rise/fall pulses for an asynchronous input.
// Edges are held off until the history flop carries a real sample, so reset never fakes an edge.
module pwm_sync_edge (
  input  logic clk,
  input  logic reset_p,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic       sync1;
  logic       sync2;
  logic       prev;
  logic [1:0] fill;
  logic       primed;

  always_ff @(posedge clk) begin
    if (reset_p) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
      fill  <= 2'd0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      prev  <= sync2;
      if (fill != 2'd3) fill <= fill + 2'd1;
    end
  end

  assign primed = (fill == 2'd3);
  assign level  = sync2;
  assign rise   = primed &  sync2 & ~prev;
  assign fall   = primed & ~sync2 &  prev;

endmodule

// File: rtl/pwm_duty_capture.sv
// Recovers the 8-bit duty of a looped-back fan PWM waveform, one strobe per period,
// with stuck-line and period-range flags.
//   state | meaning
//   IDLE  | waiting for a rise to start a full period
//   HIGH  | measuring the high phase
//   LOW   | measuring the low phase; next rise publishes
module pwm_duty_capture
  import fan_pkg::*;
#(
  parameter int CLK_HZ        = 100_000_000,
  parameter int PWM_HZ        = 100,
  parameter int RES           = 256,
  parameter int TOL           = 8,
  parameter int TIMEOUT_STEPS = 512
) (
  input  logic              clk,
  input  logic              reset_p,
  input  logic              enable,
  input  logic              pwm_in,
  output logic [DUTY_W-1:0] duty,
  output logic              duty_valid,
  output logic              stuck,
  output logic              period_err
);

  localparam int STEP  = step_clks(CLK_HZ, PWM_HZ, RES);
  localparam int SUB_W = $clog2(STEP);
  localparam int CNT_W = 10;

  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(STEP - 1);
  // The edge cycle opening a phase is not counted by sub, hence the -1.
  localparam logic [SUB_W-1:0] SUB_HALF = SUB_W'(STEP / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_TO   = CNT_W'(TIMEOUT_STEPS);
  localparam logic [CNT_W-1:0] DUTY_MAX = CNT_W'((1 << DUTY_W) - 1);
  localparam logic [CNT_W:0]   PER_LO   = (CNT_W + 1)'(RES - TOL);
  localparam logic [CNT_W:0]   PER_HI   = (CNT_W + 1)'(RES + TOL);

  state_t             state;
  state_t             state_next;
  logic               line;
  logic               rise;
  logic               fall;
  logic [SUB_W-1:0]   sub;
  logic [CNT_W-1:0]   phase_cnt;
  logic [CNT_W-1:0]   phase_rnd;
  logic [CNT_W-1:0]   high_steps;
  logic [CNT_W:0]     period;
  logic               do_start;
  logic               do_fall;
  logic               do_pub;
  logic               do_to;

  pwm_sync_edge u_sync (
    .clk     (clk),
    .reset_p (reset_p),
    .din     (pwm_in),
    .level   (line),
    .rise    (rise),
    .fall    (fall)
  );

  always_ff @(posedge clk) begin
    if (reset_p) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    do_start   = 1'b0;
    do_fall    = 1'b0;
    do_pub     = 1'b0;
    do_to      = 1'b0;
    if (!enable) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (rise) begin
            state_next = HIGH;
            do_start   = 1'b1;
          end
        end
        HIGH: begin
          if (fall) begin
            state_next = LOW;
            do_fall    = 1'b1;
          end else if (phase_cnt == CNT_TO) begin
            state_next = IDLE;
            do_to      = 1'b1;
          end
        end
        LOW: begin
          if (rise) begin
            state_next = HIGH;
            do_pub     = 1'b1;
          end else if (phase_cnt == CNT_TO) begin
            state_next = IDLE;
            do_to      = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    phase_rnd = phase_cnt;
    if (sub >= SUB_HALF && phase_cnt < CNT_TO) phase_rnd = phase_cnt + CNT_W'(1);
  end

  assign period = {1'b0, high_steps} + {1'b0, phase_rnd};

  always_ff @(posedge clk) begin
    if (reset_p) begin
      sub        <= '0;
      phase_cnt  <= '0;
      high_steps <= '0;
      duty       <= '0;
      duty_valid <= 1'b0;
      stuck      <= 1'b0;
      period_err <= 1'b0;
    end else begin
      duty_valid <= 1'b0;
      if (!enable) stuck <= 1'b0;

      if (do_pub) begin
        duty       <= (high_steps > DUTY_MAX) ? '1 : high_steps[DUTY_W-1:0];
        period_err <= (period < PER_LO) || (period > PER_HI);
        stuck      <= 1'b0;
        duty_valid <= 1'b1;
      end

      if (do_to) begin
        duty       <= line ? '1 : '0;
        stuck      <= 1'b1;
        duty_valid <= 1'b1;
      end

      if (do_fall)               high_steps <= phase_rnd;
      else if (do_start || do_pub) high_steps <= '0;

      if (do_start || do_fall || do_pub || state_next == IDLE) begin
        sub       <= '0;
        phase_cnt <= '0;
      end else if (sub == SUB_LAST) begin
        sub <= '0;
        if (phase_cnt < CNT_TO) phase_cnt <= phase_cnt + CNT_W'(1);
      end else begin
        sub <= sub + SUB_W'(1);
      end
    end
  end

endmodule
